// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Division hardware is built only when MIPS_CPU_MULDIV_DIV_EN is defined.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        op_div_q, op_div_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        is_mul_s, is_div_s, is_signed_s;
  logic        rs_neg_s, rt_neg_s;
  logic [31:0] rs_mag_s, rt_mag_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_step_s;
  logic [63:0] prod_s;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    neg64 = ~x + 64'd1;
  endfunction

  assign is_mul_s    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_signed_s = (funct == F_MULT) || (funct == F_DIV);
  assign rs_neg_s    = is_signed_s & rs_content[31];
  assign rt_neg_s    = is_signed_s & rt_content[31];
  assign rs_mag_s    = rs_neg_s ? neg32(rs_content) : rs_content;
  assign rt_mag_s    = rt_neg_s ? neg32(rt_content) : rt_content;

  // Shift-add: upper half accumulates, lower half holds the shrinking multiplier.
  assign mul_sum_s  = {1'b0, acc_q[63:32]} + {1'b0, mcand_q};
  assign mul_step_s = acc_q[0] ? {mul_sum_s, acc_q[31:1]} : {1'b0, acc_q[63:1]};
  assign prod_s     = neg_p_q ? neg64(acc_q) : acc_q;

`ifdef MIPS_CPU_MULDIV_DIV_EN
  logic [32:0] rem_sh_s;
  logic        rem_ge_s;
  logic [31:0] rem_sub_s;
  logic [63:0] div_step_s;

  // Restoring step: acc = {remainder, dividend bits shifting out / quotient bits in}.
  assign rem_sh_s   = {acc_q[63:32], acc_q[31]};
  assign rem_ge_s   = rem_sh_s >= {1'b0, mcand_q};
  assign rem_sub_s  = rem_sh_s[31:0] - mcand_q;
  assign div_step_s = rem_ge_s ? {rem_sub_s, acc_q[30:0], 1'b1}
                               : {rem_sh_s[31:0], acc_q[30:0], 1'b0};
  assign is_div_s   = (funct == F_DIV) || (funct == F_DIVU);
`else
  assign is_div_s   = 1'b0;
`endif

  // Next-state and datapath computation for every flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_div_d = op_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul_s) begin
            acc_d    = {32'd0, rt_mag_s};
            mcand_d  = rs_mag_s;
            neg_p_d  = rs_neg_s ^ rt_neg_s;
            neg_r_d  = 1'b0;
            op_div_d = 1'b0;
            cnt_d    = 6'd0;
            state_d  = S_RUN;
          end else if (is_div_s) begin
            // Zero divisor: raw dividend over zero yields all-ones quotient and rs as remainder.
            if (rt_content == 32'd0) begin
              acc_d   = {32'd0, rs_content};
              neg_p_d = 1'b0;
              neg_r_d = 1'b0;
            end else begin
              acc_d   = {32'd0, rs_mag_s};
              neg_p_d = rs_neg_s ^ rt_neg_s;
              neg_r_d = rs_neg_s;
            end
            mcand_d  = rt_mag_s;
            op_div_d = 1'b1;
            cnt_d    = 6'd0;
            state_d  = S_RUN;
          end else if (funct == F_MTHI) begin
            hi_d = rs_content;
          end else if (funct == F_MTLO) begin
            lo_d = rs_content;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef MIPS_CPU_MULDIV_DIV_EN
        if (op_div_q) begin
          acc_d = div_step_s;
        end else begin
          acc_d = mul_step_s;
        end
`else
        acc_d = mul_step_s;
`endif
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIX: begin
        if (op_div_q) begin
          lo_d = neg_p_q ? neg32(acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_r_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end else begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      op_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_div_q <= op_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
